// File: rtl/fp_pkg.sv
// Shared floating-point helpers: format geometry and the unpacked
// classification bundle used by the FP decode blocks.
package fp_pkg;

    localparam int EXP_MAX  = 11;
    localparam int MANT_MAX = 53;

    typedef struct packed {
        logic                is_zero;
        logic                is_nan;
        logic                is_inf;
        logic                sign;
        logic [EXP_MAX-1:0]  exp;
        logic [MANT_MAX-1:0] mant;
    } fp_class_t;

    function automatic int fp_fw(input int w);
        return (w == 64) ? 52 : 23;
    endfunction

    function automatic int fp_ew(input int w);
        return (w == 64) ? 11 : 8;
    endfunction

    function automatic int fp_bias(input int w);
        return (1 << (fp_ew(w) - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 classifier: splits a packed float into
// sign, biased exponent and hidden-bit mantissa plus special flags.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    output fp_class_t    cls
);

    localparam int FW = fp_fw(W);
    localparam int EW = fp_ew(W);

    logic [EW-1:0] e;
    logic [FW-1:0] f;

    assign e = in[W-2:FW];
    assign f = in[FW-1:0];

    always_comb begin
        cls         = '0;
        cls.sign    = in[W-1];
        cls.exp     = EXP_MAX'(e);
        cls.is_zero = (e == '0);
        cls.is_nan  = (&e) & (|f);
        cls.is_inf  = (&e) & ~(|f);
        cls.mant    = MANT_MAX'({1'b1, f});
    end

endmodule

// File: rtl/fp_to_fixed.sv
// Three-stage float to signed fixed-point converter:
// classify, align with guard/sticky, round-to-even and saturate.
module fp_to_fixed
    import fp_pkg::*;
#(
    parameter int W    = 32,
    parameter int OW   = 32,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out,
    output logic          out_ovf
);

    localparam int FW     = fp_fw(W);
    localparam int EW     = fp_ew(W);
    localparam int BIAS   = fp_bias(W);
    localparam int SW     = EW + 2;
    localparam int MW     = ((OW > FW + 1) ? OW : FW + 1) + 1;
    localparam int XW     = 2 * FW + 3;
    localparam int SH_OFF = BIAS + FW - FRAC;
    localparam int LMAX   = OW - FW - 1;

    localparam logic [MW-1:0] LIM     = MW'(1) << (OW - 1);
    localparam logic [OW-1:0] POS_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] NEG_MIN = {1'b1, {(OW-1){1'b0}}};

    fp_class_t cls;
    logic      unused_cls;

    fp_unpack #(.W(W)) u_unpack (
        .in  (in),
        .cls (cls)
    );

    assign unused_cls = ^{cls.exp, cls.mant};

    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv, s3_adv, in_fire;

    assign s3_adv   = out_valid & out_ready;
    assign s2_adv   = s2_valid & (~out_valid | s3_adv);
    assign s1_adv   = s1_valid & (~s2_valid | s2_adv);
    assign in_ready = ~s1_valid | s1_adv;
    assign in_fire  = in_valid & in_ready;

    logic                 s1_zero, s1_nan, s1_inf, s1_sign;
    logic [FW:0]          s1_mant;
    logic signed [SW-1:0] s1_sh, sh_c;

    assign sh_c = $signed({2'b00, cls.exp[EW-1:0]})
                - $signed(SW'(SH_OFF));

    logic [MW-1:0] mag_c;
    logic          guard_c, sticky_c, big_c;
    logic [SW-1:0] nsh;
    logic [XW-1:0] ext;

    // Right shifts past FW+2 all collapse to "only sticky survives".
    always_comb begin
        mag_c    = '0;
        guard_c  = 1'b0;
        sticky_c = 1'b0;
        big_c    = 1'b0;
        nsh      = '0;
        ext      = '0;
        if (!s1_sh[SW-1]) begin
            if (s1_sh > $signed(SW'(LMAX))) begin
                big_c = 1'b1;
            end else begin
                mag_c = MW'(s1_mant) << s1_sh;
            end
        end else begin
            nsh = SW'(-s1_sh);
            if (nsh > SW'(FW + 2)) begin
                nsh = SW'(FW + 2);
            end
            ext      = {s1_mant, {(FW+2){1'b0}}} >> nsh;
            mag_c    = MW'(ext[XW-1:FW+2]);
            guard_c  = ext[FW+1];
            sticky_c = |ext[FW:0];
        end
    end

    logic          s2_sign, s2_zero, s2_nan, s2_sat;
    logic          s2_guard, s2_sticky;
    logic [MW-1:0] s2_mag;

    logic [MW-1:0] rnd;
    logic [OW-1:0] res_c;
    logic          ovf_c;

    // A magnitude of exactly 2^(OW-1) is still representable when negative.
    always_comb begin
        rnd   = s2_mag + MW'(s2_guard & (s2_sticky | s2_mag[0]));
        res_c = '0;
        ovf_c = 1'b0;
        if (s2_zero) begin
            res_c = '0;
            ovf_c = s2_nan;
        end else if (s2_sat || rnd > LIM || (rnd == LIM && !s2_sign)) begin
            res_c = s2_sign ? NEG_MIN : POS_MAX;
            ovf_c = 1'b1;
        end else begin
            res_c = s2_sign ? -rnd[OW-1:0] : rnd[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid <= 1'b1;
            end else if (s2_adv) begin
                s2_valid <= 1'b0;
            end
            if (s2_adv) begin
                out_valid <= 1'b1;
            end else if (s3_adv) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_zero <= cls.is_zero;
            s1_nan  <= cls.is_nan;
            s1_inf  <= cls.is_inf;
            s1_sign <= cls.sign;
            s1_mant <= cls.mant[FW:0];
            s1_sh   <= sh_c;
        end
        if (s1_adv) begin
            s2_sign   <= s1_sign;
            s2_zero   <= s1_zero | s1_nan;
            s2_nan    <= s1_nan;
            s2_sat    <= s1_inf | (big_c & ~s1_zero & ~s1_nan);
            s2_mag    <= mag_c;
            s2_guard  <= guard_c;
            s2_sticky <= sticky_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= '0;
            out_ovf <= 1'b0;
        end else if (s2_adv) begin
            out     <= res_c;
            out_ovf <= ovf_c;
        end
    end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Self-checking bench for fp_to_fixed (W=32, OW=32, FRAC=8) against
// an arithmetic quotient/remainder reference model.
module tb_fp_to_fixed;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    fp_to_fixed #(.W(32), .OW(32), .FRAC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (fp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // value = m * 2^(e-150); scaled by 2^8 -> m * 2^(e-142)
    function automatic logic [32:0] ref_conv(input logic [31:0] x);
        int              e, k, n;
        logic            s;
        longint unsigned m, q, rem, half;
        logic [31:0]     t;
        s = x[31];
        e = int'(x[30:23]);
        m = 64'(x[22:0]) + 64'h80_0000;
        if (e == 0) return {1'b0, 32'h0};
        if (e == 255) begin
            if (x[22:0] != 0) return {1'b1, 32'h0};
            return {1'b1, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
        end
        k = e - 142;
        if (k > 40) begin
            q = 64'hFFFF_FFFF_FFFF;
        end else if (k >= 0) begin
            q = m << k;
        end else if (-k > 30) begin
            q = 0;
        end else begin
            n    = -k;
            q    = m >> n;
            rem  = m - (q << n);
            half = 64'd1 << (n - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (s && q == 64'h8000_0000) return {1'b0, 32'h8000_0000};
        if (q > 64'h7FFF_FFFF) return {1'b1, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
        t = q[31:0];
        if (s) t = -t;
        return {1'b0, t};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w[31]    = 1'($urandom_range(0, 1));
        w[30:23] = 8'($urandom_range(100, 165));
        w[22:0]  = 23'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            w[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] x, input logic [31:0] eo,
                            input logic ev, input string name);
        fp_in     = x;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s early out_valid at edge %0d", name, i);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: out_valid=%b want 1", name, out_valid);
        end
        checks++;
        if (out !== eo || out_ovf !== ev) begin
            errors++;
            $display("FAIL %s value: got %h/%b want %h/%b",
                     name, out, out_ovf, eo, ev);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s drain: out_valid stays 1", name);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fp_in     = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%h ovf=%b want 0/0/0",
                     out_valid, out, out_ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_directed();
        send_one(32'h3F80_0000, 32'h0000_0100, 1'b0, "one");
        send_one(32'hC020_0000, 32'hFFFF_FD80, 1'b0, "neg2p5");
        send_one(32'h3B00_0000, 32'h0000_0000, 1'b0, "rnd_half");
        send_one(32'h3BC0_0000, 32'h0000_0002, 1'b0, "rnd_1p5");
        send_one(32'h3C20_0000, 32'h0000_0002, 1'b0, "rnd_2p5");
        send_one(32'h4B00_0000, 32'h7FFF_FFFF, 1'b1, "sat_pos");
        send_one(32'hCB00_0000, 32'h8000_0000, 1'b0, "neg_min");
        send_one(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, "pinf");
        send_one(32'hFF80_0000, 32'h8000_0000, 1'b1, "ninf");
        send_one(32'h7FC0_0000, 32'h0000_0000, 1'b1, "nan");
        send_one(32'h8000_0000, 32'h0000_0000, 1'b0, "neg_zero");
        send_one(32'h0000_0001, 32'h0000_0000, 1'b0, "denorm");
    endtask

    task automatic test_random_singles();
        logic [31:0] w;
        logic [32:0] r;
        for (int i = 0; i < 16; i++) begin
            w = rand_word();
            r = ref_conv(w);
            send_one(w, r[31:0], r[32], "rand_single");
        end
    endtask

    task automatic stream(input int n, input bit bp, input string name);
        logic [31:0] words[$];
        logic [32:0] expq[$];
        logic [32:0] e;
        logic [31:0] held_o;
        logic        held_f;
        bit          stalled, in_f, out_f, exp_rdy;
        int          sent, got, occ, cyc;
        sent = 0; got = 0; occ = 0; cyc = 0; stalled = 0;
        held_o = '0; held_f = 1'b0;
        for (int i = 0; i < n; i++) words.push_back(rand_word());
        while (got < n && cyc < 400) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (sent < n);
            fp_in     = (sent < n) ? words[sent] : 32'h0;
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out !== held_o || out_ovf !== held_f) begin
                    errors++;
                    $display("FAIL %s stall_hold: got %b/%h/%b want 1/%h/%b",
                             name, out_valid, out, out_ovf, held_o, held_f);
                end
            end
            exp_rdy = !(occ == 3 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL %s in_ready: got %b want %b occ=%0d",
                         name, in_ready, exp_rdy, occ);
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL %s spurious output %h", name, out);
                end else begin
                    e = expq.pop_front();
                    if (out !== e[31:0] || out_ovf !== e[32]) begin
                        errors++;
                        $display("FAIL %s data: got %h/%b want %h/%b",
                                 name, out, out_ovf, e[31:0], e[32]);
                    end
                end
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held_o  = out;
            held_f  = out_ovf;
            in_f    = in_valid && (in_ready === 1'b1);
            out_f   = (out_valid === 1'b1) && out_ready;
            @(posedge clk);
            #1;
            if (in_f) begin
                expq.push_back(ref_conv(words[sent]));
                sent++;
                occ++;
            end
            if (out_f) begin
                got++;
                occ--;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s timeout: got %0d of %0d", name, got, n);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        stream(10, 1'b0, "back_to_back");
    endtask

    task automatic test_backpressure();
        stream(8, 1'b1, "backpressure");
        stream(24, 1'b1, "backpressure_long");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fp_in    = rand_word();
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid fill %0d: in_ready=%b want 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid full: in_ready=%b out_valid=%b want 0/1",
                     in_ready, out_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid flush: out_valid=%b in_ready=%b want 0/1",
                     out_valid, in_ready);
        end
        send_one(32'h3F80_0000, 32'h0000_0100, 1'b0, "reset_mid_after");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_singles();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
